// File: rtl/scrambler_gen.sv
// scrambler_gen: draws a sequence of pseudo-random indices from a 16-bit LFSR.
// Each index is in 0..range-1, and the indices are stored in a small register
// memory that can be read back at any time.
//
// Optional feature macro: SCRAMBLER_NOREPEAT_EN
//   When it is defined, a candidate that equals the previously accepted index
//   is rejected for every index after the first in a sequence. The check only
//   applies when the latched range is >= 2.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; the LFSR keeps free-running
// DRAW   | one candidate per cycle; accepted ones are stored in mem
// DONE   | single-cycle completion pulse, then back to IDLE
module scrambler_gen #(
  parameter int IDX_W = 3,
  parameter int DEPTH = 6,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rng_gen,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [IDX_W:0]   range,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [IDX_W-1:0] rd_data,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);

  logic [1:0]       state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             lfsr_fb;
  logic [LEN_W-1:0] count, len_q;
  logic [LEN_W-1:0] len_clamp, count_inc;
  logic [IDX_W:0]   range_q, range_fix;
  logic [IDX_W-1:0] prev;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] mem [DEPTH];
  logic             draw_open;
  logic             in_range;
  logic             repeat_hit;
  logic             accept;
  logic             start_ok;

  // LFSR next value, with lock-up escape back to the seed
  always_comb begin
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10] ^ rng_gen;
    lfsr_nxt = {lfsr[14:0], lfsr_fb};
    if (lfsr_nxt == 16'h0000) begin
      lfsr_nxt = LFSR_SEED;
    end
  end

  // Request sanitising: len is clamped to the storage depth, range 0 acts as 1
  always_comb begin
    len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    range_fix = (range == '0) ? (IDX_W+1)'(1) : range;
    start_ok  = (state == S_IDLE) && start;
  end

  // Candidate formation and acceptance. With a single legal index the
  // candidate is forced to 0, so every DRAW cycle yields an index.
  always_comb begin
    cand       = (range_q == (IDX_W+1)'(1)) ? '0 : lfsr[IDX_W-1:0];
    in_range   = ({1'b0, cand} < range_q);
    draw_open  = (count < len_q);
    count_inc  = count + 1'b1;
`ifdef SCRAMBLER_NOREPEAT_EN
    repeat_hit = (count != '0) && (range_q >= (IDX_W+1)'(2)) && (cand == prev);
`else
    repeat_hit = 1'b0;
`endif
    accept     = (state == S_DRAW) && draw_open && in_range && !repeat_hit;
  end

`ifndef SCRAMBLER_NOREPEAT_EN
  // prev is still tracked in this build, but it never affects acceptance
  logic unused_prev;
  assign unused_prev = ^prev;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (!draw_open) begin
          state_nxt = S_DONE;
        end else if (accept && (count_inc == len_q)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, LFSR, request latches and the index memory
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      count   <= '0;
      prev    <= '0;
      len_q   <= '0;
      range_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      if (start_ok) begin
        len_q   <= len_clamp;
        range_q <= range_fix;
        count   <= '0;
      end
      if (accept) begin
        count <= count_inc;
        prev  <= cand;
        for (int i = 0; i < DEPTH; i++) begin
          if (count == LEN_W'(i)) mem[i] <= cand;
        end
      end
    end
  end

  // Read port: out-of-range addresses return 0
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == LEN_W'(i)) rd_data = mem[i];
    end
  end

  // Status outputs
  always_comb begin
    idx_valid = accept;
    idx_out   = accept ? cand : '0;
    busy      = (state == S_DRAW);
    done      = (state == S_DONE);
  end

endmodule
